multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Multi-cycle control FSM for the RV32I-subset core.
- Sequences fetch, decode, execute, memory and write-back over one shared ALU and one shared instruction/data memory port.
- Decodes the instruction register into the team's 4-bit ALU control codes and drives every datapath strobe.
- Waits on a ready-handshake memory and halts on illegal instructions or memory timeouts.

## Interface

Parameters
- WAIT_MAX, default 15: maximum consecutive stall cycles allowed on a memory request before a bus fault; legal range 1–255.

Ports
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction register contents; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  request is a write; stable while mem_req=1.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result register (data access).
- ir_we  out  1  latch instruction register.
- pc_we  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- alu_src_b  out  1  0 = rs2, 1 = sign-extended immediate.
- alu_ctrl  out  4  ALU operation code.
- reg_we  out  1  register-file write enable.
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = memory data.
- halted  out  1  FSM is in HALT.
- fault  out  2  00 none, 01 illegal instruction, 10 bus timeout; sticky.

## Operation

- States:
  - FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. When mem_ready=1: ir_we=1, pc_we=1, pc_src=0 in the same cycle, then next state is DECODE.
  - DECODE: no strobes. Next state is EXEC if the instruction is legal, else HALT with fault=01.
  - EXEC: alu_ctrl and alu_src_b driven from the decode.
    - R-type and I-type: go to WB.
    - LW and SW: go to MEM.
    - BEQ: if zero=1, assert pc_we=1 with pc_src=1; then go to FETCH.
  - MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SW.
    - On mem_ready=1: LW goes to WB; SW goes to FETCH.
  - WB: reg_we=1; wb_sel=1 for LW, 0 otherwise; then go to FETCH.
  - HALT: all strobes 0, halted=1. Exits only on reset.
- Legal instructions, matched on {funct7[5], funct3, opcode}, with alu_ctrl value:
  - ADD 0_000_0110011 → 0010
  - SUB 1_000_0110011 → 0110
  - AND 0_111_0110011 → 0000
  - OR 0_110_0110011 → 0001
  - ADDI x_000_0010011 → 1010
  - ANDI x_111_0010011 → 1000
  - ORI x_110_0010011 → 1001
  - LW x_010_0000011 → 1010
  - SW x_010_0100011 → 1010
  - BEQ x_000_1100011 → 0110
  - Anything else is illegal.
- alu_src_b=1 for ADDI, ANDI, ORI, LW and SW; 0 for R-type and BEQ.
- alu_ctrl outside EXEC is 0010 (don't-care to the datapath, but fixed for the bench).
- Wait counter (8 bits):
  - Clears on entry to FETCH or MEM and on every mem_ready=1.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If it equals WAIT_MAX while mem_ready=0: next state is HALT with fault=10, and no strobes fire.
  - mem_ready=1 in that same cycle wins: the request completes normally.

## Timing

- Reset: state=FETCH, counter=0, fault=00, halted=0.
  - While reset=1, every output is 0 (mem_req gated by !reset) and alu_ctrl=0010.
  - First fetch request is asserted in the first cycle after reset deasserts.
- Reset mid-operation overrides everything. An outstanding memory request is dropped; the memory must tolerate mem_req falling without mem_ready.
- Outputs are combinational from the state register plus instr. FETCH/MEM completion strobes, and the BEQ pc_we, are additionally qualified by mem_ready or zero in the same cycle.
- Cycles per instruction with zero-wait memory (mem_ready tied high):
  - R/I-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3 (taken or not)
  - Each stall cycle adds 1.
- mem_we and mem_addr_sel must not change while mem_req=1 and mem_ready=0.
- At most one of ir_we, reg_we, or a taken-branch pc_we is asserted in any cycle. pc_we in FETCH coincides only with ir_we.

## Test plan

- mem_ready tied 1, instr=ADD (0x002081B3) → states FETCH, DECODE, EXEC, WB; alu_ctrl=0010 in EXEC, alu_src_b=0; reg_we=1 in cycle 4 only.
- LW with mem_ready low for 3 cycles in MEM → mem_req held 4 cycles with mem_addr_sel=1, mem_we=0; then WB with wb_sel=1; total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0 → pc_we=1, pc_src=1 in EXEC only for the first; both return to FETCH after 3 cycles.
- Illegal instr 0x0020C1B3 (XOR) → HALT after DECODE; fault=01, halted=1, no reg_we or pc_we; stays halted until a reset pulse, then FETCH.
- WAIT_MAX=15, mem_ready held 0 in FETCH → HALT with fault=10 after 16 request cycles. Repeat with mem_ready=1 on that 16th cycle → normal ir_we, no fault.
- reset asserted in MEM during a SW stall → next cycle FETCH, mem_req=0 during reset, fault=00, mem_we never pulsed with mem_ready.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle controller (master) and the
// datapath plus shared memory (slave).
//
// Memory handshake: mem_req is a request qualified by mem_ready in the same cycle.
// The transfer completes on the cycle where mem_req=1 and mem_ready=1.
// Until then, mem_req, mem_we and mem_addr_sel stay stable. Only reset may withdraw
// the request.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        alu_src_b;
  logic [3:0]  alu_ctrl;
  logic        reg_we;
  logic        wb_sel;
  logic        halted;
  logic [1:0]  fault;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
           alu_ctrl, reg_we, wb_sel, halted, fault
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
           alu_ctrl, reg_we, wb_sel, halted, fault
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the RV32I-subset core.
// It has a shared memory port with a stall timeout, and a sticky fault/halt state.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus,
  output logic [2:0]          state_dbg_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_ALU = 2'd0,
    OP_LW  = 2'd1,
    OP_SW  = 2'd2,
    OP_BEQ = 2'd3
  } op_e;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);
  localparam logic [3:0] ALU_ADD    = 4'b0010;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] fault_q, fault_d;

  logic       dec_legal;
  logic [3:0] dec_alu;
  logic       dec_src_b;
  op_e        dec_op;
  logic [10:0] dec_key;

  logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_we_c, pc_we_c, pc_src_c;
  logic       alu_src_b_c, reg_we_c, wb_sel_c, halted_c;
  logic [3:0] alu_ctrl_c;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Match key is {funct7[5], funct3, opcode}.
  assign dec_key = {bus.instr[30], bus.instr[14:12], bus.instr[6:0]};

  always_comb begin
    dec_legal = 1'b1;
    dec_alu   = ALU_ADD;
    dec_src_b = 1'b0;
    dec_op    = OP_ALU;
    casez (dec_key)
      11'b0_000_0110011: dec_alu = 4'b0010;
      11'b1_000_0110011: dec_alu = 4'b0110;
      11'b0_111_0110011: dec_alu = 4'b0000;
      11'b0_110_0110011: dec_alu = 4'b0001;
      11'b?_000_0010011: begin dec_alu = 4'b1010; dec_src_b = 1'b1; end
      11'b?_111_0010011: begin dec_alu = 4'b1000; dec_src_b = 1'b1; end
      11'b?_110_0010011: begin dec_alu = 4'b1001; dec_src_b = 1'b1; end
      11'b?_010_0000011: begin dec_alu = 4'b1010; dec_src_b = 1'b1; dec_op = OP_LW; end
      11'b?_010_0100011: begin dec_alu = 4'b1010; dec_src_b = 1'b1; dec_op = OP_SW; end
      11'b?_000_1100011: begin dec_alu = 4'b0110; dec_op = OP_BEQ; end
      default:           dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = 8'd0;
    fault_d        = fault_q;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_src_c       = 1'b0;
    alu_src_b_c    = 1'b0;
    alu_ctrl_c     = ALU_ADD;
    reg_we_c       = 1'b0;
    wb_sel_c       = 1'b0;
    halted_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == WAIT_LIMIT) begin
          state_d = S_HALT;
          fault_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          fault_d = 2'b01;
        end
      end
      S_EXEC: begin
        alu_ctrl_c  = dec_alu;
        alu_src_b_c = dec_src_b;
        case (dec_op)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ: begin
            pc_we_c  = bus.zero;
            pc_src_c = bus.zero;
            state_d  = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (dec_op == OP_SW);
        if (bus.mem_ready) begin
          state_d = (dec_op == OP_LW) ? S_WB : S_FETCH;
        end else if (cnt_q == WAIT_LIMIT) begin
          state_d = S_HALT;
          fault_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        wb_sel_c = (dec_op == OP_LW);
        state_d  = S_FETCH;
      end
      S_HALT: halted_c = 1'b1;
      default: state_d = S_HALT;
    endcase
  end

  // Reset silences every output, including the FETCH request implied by the reset state.
  assign bus.mem_req      = mem_req_c      & ~reset;
  assign bus.mem_we       = mem_we_c       & ~reset;
  assign bus.mem_addr_sel = mem_addr_sel_c & ~reset;
  assign bus.ir_we        = ir_we_c        & ~reset;
  assign bus.pc_we        = pc_we_c        & ~reset;
  assign bus.pc_src       = pc_src_c       & ~reset;
  assign bus.alu_src_b    = alu_src_b_c    & ~reset;
  assign bus.alu_ctrl     = reset ? ALU_ADD : alu_ctrl_c;
  assign bus.reg_we       = reg_we_c       & ~reset;
  assign bus.wb_sel       = wb_sel_c       & ~reset;
  assign bus.halted       = halted_c       & ~reset;
  assign bus.fault        = reset ? 2'b00 : fault_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-accurate bench for multicycle_ctrl. The bench builds per-instruction phase sequences,
// driven-input/expected-output pairs, and compares every output cycle by cycle.
module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 15;
  localparam int OW       = 16;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       alu_src_b;
    logic [3:0] alu_ctrl;
    logic       reg_we;
    logic       wb_sel;
    logic       halted;
    logic [1:0] fault;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    logic        rst;
  } stim_t;

  // cls: 0 = register/immediate ALU op, 1 = LW, 2 = SW, 3 = BEQ
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  alu;
    logic        srcb;
    int          cls;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] state_dbg;
  multicycle_ctrl_if bus();

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  op_t          tab[10];
  stim_t        stim_q[$];
  logic [OW-1:0] exp_q[$];
  logic [31:0]  m_instr;
  logic         m_zero;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check_eq(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t idle();
    out_t o;
    o = '0;
    o.alu_ctrl = 4'b0010;
    return o;
  endfunction

  function automatic int lookup(input logic [31:0] w);
    for (int i = 0; i < 10; i++)
      if ((w & tab[i].mask) == tab[i].match) return i;
    return -1;
  endfunction

  function automatic logic [31:0] gen_word(input int k);
    logic [31:0] w;
    w = $urandom;
    return (w & ~tab[k].mask) | tab[k].match;
  endfunction

  function automatic logic [31:0] gen_illegal();
    logic [31:0] w;
    w = $urandom;
    while (lookup(w) >= 0) w = $urandom;
    return w;
  endfunction

  task automatic push(input out_t o, input logic rdy, input logic rst);
    stim_t s;
    s.instr = m_instr;
    s.zero  = m_zero;
    s.rdy   = rdy;
    s.rst   = rst;
    stim_q.push_back(s);
    exp_q.push_back(o);
  endtask

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) push(idle(), rnd(), 1'b1);
  endtask

  task automatic push_halt(input logic [1:0] f);
    out_t o;
    o = idle();
    o.halted = 1'b1;
    o.fault  = f;
    for (int i = 0; i < 3; i++) push(o, rnd(), 1'b0);
    push_reset(1);
  endtask

  // res: 0 completed, 1 timed out, 2 aborted by reset
  task automatic mem_phase(input logic is_mem, input logic we, input int stall,
                           input int abort_at, output int res);
    out_t o, c;
    int   i;
    o = idle();
    o.mem_req      = 1'b1;
    o.mem_addr_sel = is_mem;
    o.mem_we       = we;
    i = 0;
    res = 0;
    while (1) begin
      if (i == abort_at) begin
        push(idle(), 1'b0, 1'b1);
        res = 2;
        return;
      end
      if (i == stall) begin
        c = o;
        if (!is_mem) begin
          c.ir_we = 1'b1;
          c.pc_we = 1'b1;
        end
        push(c, 1'b1, 1'b0);
        return;
      end
      push(o, 1'b0, 1'b0);
      if (i == WAIT_MAX) begin
        res = 1;
        return;
      end
      i++;
    end
  endtask

  task automatic model_instr(input logic [31:0] w, input logic z, input int sf,
                             input int sm, input int abort_mem);
    int   res, k;
    out_t o;
    m_instr = w;
    m_zero  = z;
    mem_phase(1'b0, 1'b0, sf, -1, res);
    if (res == 1) begin push_halt(2'b10); return; end
    push(idle(), rnd(), 1'b0);
    k = lookup(w);
    if (k < 0) begin push_halt(2'b01); return; end
    o = idle();
    o.alu_ctrl  = tab[k].alu;
    o.alu_src_b = tab[k].srcb;
    if (tab[k].cls == 3 && z) begin
      o.pc_we  = 1'b1;
      o.pc_src = 1'b1;
    end
    push(o, rnd(), 1'b0);
    if (tab[k].cls == 3) return;
    if (tab[k].cls != 0) begin
      mem_phase(1'b1, tab[k].cls == 2, sm, abort_mem, res);
      if (res == 1) begin push_halt(2'b10); return; end
      if (res == 2 || tab[k].cls == 2) return;
    end
    o = idle();
    o.reg_we = 1'b1;
    o.wb_sel = (tab[k].cls == 1);
    push(o, rnd(), 1'b0);
  endtask

  function automatic logic [OW-1:0] sample();
    out_t a;
    a.mem_req      = bus.mem_req;
    a.mem_we       = bus.mem_we;
    a.mem_addr_sel = bus.mem_addr_sel;
    a.ir_we        = bus.ir_we;
    a.pc_we        = bus.pc_we;
    a.pc_src       = bus.pc_src;
    a.alu_src_b    = bus.alu_src_b;
    a.alu_ctrl     = bus.alu_ctrl;
    a.reg_we       = bus.reg_we;
    a.wb_sel       = bus.wb_sel;
    a.halted       = bus.halted;
    a.fault        = bus.fault;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t        s;
    logic [OW-1:0] e;
    int           cyc;
    int           k, sf, sm;

    tab[0] = '{32'h4000707F, 32'h00000033, 4'b0010, 1'b0, 0};
    tab[1] = '{32'h4000707F, 32'h40000033, 4'b0110, 1'b0, 0};
    tab[2] = '{32'h4000707F, 32'h00007033, 4'b0000, 1'b0, 0};
    tab[3] = '{32'h4000707F, 32'h00006033, 4'b0001, 1'b0, 0};
    tab[4] = '{32'h0000707F, 32'h00000013, 4'b1010, 1'b1, 0};
    tab[5] = '{32'h0000707F, 32'h00007013, 4'b1000, 1'b1, 0};
    tab[6] = '{32'h0000707F, 32'h00006013, 4'b1001, 1'b1, 0};
    tab[7] = '{32'h0000707F, 32'h00002003, 4'b1010, 1'b1, 1};
    tab[8] = '{32'h0000707F, 32'h00002023, 4'b1010, 1'b1, 2};
    tab[9] = '{32'h0000707F, 32'h00000063, 4'b0110, 1'b0, 3};

    reset         = 1'b1;
    bus.instr     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    m_instr       = '0;
    m_zero        = 1'b0;

    // Directed scenarios
    push_reset(2);
    model_instr(32'h002081B3, 1'b0, 0, 0, -1);                  // ADD, zero-wait
    model_instr(gen_word(7), 1'b0, 0, 3, -1);                   // LW, 3 MEM stalls
    model_instr(gen_word(9), 1'b1, 0, 0, -1);                   // BEQ taken
    model_instr(gen_word(9), 1'b0, 0, 0, -1);                   // BEQ not taken
    model_instr(32'h0020C1B3, 1'b0, 0, 0, -1);                  // XOR is illegal
    model_instr(32'h002081B3, 1'b0, 99, 0, -1);                 // fetch timeout
    model_instr(32'h002081B3, 1'b0, WAIT_MAX, 0, -1);           // ready on the last allowed cycle
    model_instr(gen_word(8), 1'b0, 0, WAIT_MAX, -1);            // SW ready on the last allowed cycle
    model_instr(gen_word(7), 1'b0, 1, 99, -1);                  // MEM timeout
    model_instr(gen_word(8), 1'b0, 0, 5, 2);                    // reset during SW stall
    model_instr(gen_word(8), 1'b0, 0, 0, -1);                   // SW zero-wait

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 10);
      sf = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
      sm = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
      if (k == 10 && $urandom_range(0, 3) == 0)
        model_instr(gen_illegal(), rnd(), sf, sm, -1);
      else
        model_instr(gen_word(k % 10), rnd(), sf, sm, -1);
    end

    cyc = 0;
    @(posedge clk);
    #1;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      reset         = s.rst;
      bus.instr     = s.instr;
      bus.zero      = s.zero;
      bus.mem_ready = s.rdy;
      @(negedge clk);
      check_eq($sformatf("cyc%0d", cyc), sample(), e);
      @(posedge clk);
      #1;
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
